// File: rtl/lc3b_types.sv
// Shared LC-3b types for the branch target buffer: word type, 2-bit counter,
// table entry and the one-deep resolve/update record.
package lc3b_types;

  localparam int BTB_IDX_BITS = 4;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } lc3b_btb_ctr;

  // The tag field is a full word so the struct stays valid for any index width.
  typedef struct packed {
    logic        valid;
    lc3b_word    tag;
    lc3b_word    target;
    lc3b_btb_ctr ctr;
  } lc3b_btb_entry;

  typedef struct packed {
    logic     valid;
    lc3b_word pc;
    lc3b_word target;
    logic     taken;
    logic     unconditional;
    logic     mispredict;
    logic     incorrect_target;
  } lc3b_btb_update;

  function automatic lc3b_word btb_tag(lc3b_word pc, int idx_bits);
    return pc >> (idx_bits + 1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Resolve-stage bus into the BTB: the resolved instruction's outcome and the
// misprediction flags raised for it.
interface branch_predictor_btb_if;
  import lc3b_types::*;

  logic     resolve_valid;
  lc3b_word resolve_pc;
  lc3b_word resolve_target;
  logic     resolve_taken;
  logic     resolve_unconditional;
  logic     incorrectly_taken;
  logic     incorrectly_not_taken;
  logic     incorrect_target;

  modport master (
    output resolve_valid, resolve_pc, resolve_target, resolve_taken,
           resolve_unconditional, incorrectly_taken, incorrectly_not_taken,
           incorrect_target
  );

  modport slave (
    input resolve_valid, resolve_pc, resolve_target, resolve_taken,
          resolve_unconditional, incorrectly_taken, incorrectly_not_taken,
          incorrect_target
  );

endinterface

// File: rtl/branch_predictor_btb_array.sv
// BTB storage: one write port, a raw read port for read-modify-write and a
// lookup port that forwards the entry being written this cycle.
module btb_array
  import lc3b_types::*;
#(
  parameter int IDX_BITS = BTB_IDX_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output lc3b_btb_entry       rd_entry,
  input  logic [IDX_BITS-1:0] upd_idx,
  output lc3b_btb_entry       upd_entry,
  input  logic                wr_en,
  input  lc3b_btb_entry       wr_entry
);

  localparam int ENTRIES = 1 << IDX_BITS;

  lc3b_btb_entry mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every entry is reset because cold misses and the WNT starting
      // counter are visible behaviour; this keeps the table in flops, not RAM.
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (wr_en) begin
      mem[upd_idx] <= wr_entry;
    end
  end

  assign upd_entry = mem[upd_idx];
  assign rd_entry  = (wr_en && (upd_idx == rd_idx)) ? wr_entry : mem[rd_idx];

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup
// on fetch_pc, resolves applied one edge after capture by read-modify-write.
module branch_predictor_btb
  import lc3b_types::lc3b_word, lc3b_types::lc3b_btb_ctr, lc3b_types::lc3b_btb_entry,
         lc3b_types::lc3b_btb_update, lc3b_types::btb_tag,
         lc3b_types::SNT, lc3b_types::WT, lc3b_types::ST;
#(
  parameter int BTB_IDX_BITS = lc3b_types::BTB_IDX_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  lc3b_word                     fetch_pc,
  output logic                         branch_predictor_taken_and_btb_valid,
  output logic                         btb_hit,
  output lc3b_word                     btb_target,
  branch_predictor_btb_if.slave        res,
  output lc3b_word                     mispredict_count
);

  lc3b_btb_update            upd;
  lc3b_btb_entry             rd_entry;
  lc3b_btb_entry             old_entry;
  lc3b_btb_entry             new_entry;
  logic                      upd_hit;
  logic                      upd_write;
  logic                      wr_en;
  logic [BTB_IDX_BITS-1:0]   fetch_idx;
  logic [BTB_IDX_BITS-1:0]   upd_idx;

  assign fetch_idx = fetch_pc[BTB_IDX_BITS:1];
  assign upd_idx   = upd.pc[BTB_IDX_BITS:1];

  // NOTE: state is written with <= so every flop samples pre-edge values,
  // independent of the order in which the simulator runs the blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd <= '0;
    end else begin
      upd.valid            <= res.resolve_valid;
      upd.pc               <= res.resolve_pc;
      upd.target           <= res.resolve_target;
      upd.taken            <= res.resolve_taken;
      upd.unconditional    <= res.resolve_unconditional;
      upd.mispredict       <= res.incorrectly_taken | res.incorrectly_not_taken |
                              res.incorrect_target;
      upd.incorrect_target <= res.incorrect_target;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    new_entry = old_entry;
    upd_write = 1'b0;
    upd_hit   = old_entry.valid && (old_entry.tag == btb_tag(upd.pc, BTB_IDX_BITS));
    if (upd_hit) begin
      upd_write = 1'b1;
      if (upd.unconditional) begin
        new_entry.ctr = ST;
      end else if (upd.taken) begin
        new_entry.ctr = (old_entry.ctr == ST) ? ST : lc3b_btb_ctr'(old_entry.ctr + 2'd1);
      end else begin
        new_entry.ctr = (old_entry.ctr == SNT) ? SNT : lc3b_btb_ctr'(old_entry.ctr - 2'd1);
      end
      if (upd.taken && (upd.incorrect_target || (old_entry.target != upd.target))) begin
        new_entry.target = upd.target;
      end
    end else if (upd.taken) begin
      // Miss with a taken outcome replaces whatever occupied the slot.
      upd_write = 1'b1;
      new_entry = '{valid: 1'b1, tag: btb_tag(upd.pc, BTB_IDX_BITS), target: upd.target,
                    ctr: upd.unconditional ? ST : WT};
    end
  end

  assign wr_en = upd.valid && upd_write;

  btb_array #(.IDX_BITS(BTB_IDX_BITS)) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (fetch_idx),
    .rd_entry  (rd_entry),
    .upd_idx   (upd_idx),
    .upd_entry (old_entry),
    .wr_en     (wr_en),
    .wr_entry  (new_entry)
  );

  assign btb_hit = rd_entry.valid && (rd_entry.tag == btb_tag(fetch_pc, BTB_IDX_BITS));
  assign branch_predictor_taken_and_btb_valid = btb_hit && rd_entry.ctr[1];
  assign btb_target = btb_hit ? rd_entry.target : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (upd.valid && upd.mispredict && (mispredict_count != 16'hFFFF)) begin
      mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios followed by
// random resolves, all compared against a table-level reference model.
module tb_branch_predictor_btb;

  localparam int IDX = 4;
  localparam int N   = 1 << IDX;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        taken_o;
  logic        hit_o;
  logic [15:0] target_o;
  logic [15:0] mcount_o;

  branch_predictor_btb_if bus ();

  branch_predictor_btb #(.BTB_IDX_BITS(IDX)) dut (
    .clk                                  (clk),
    .reset                                (reset),
    .fetch_pc                             (fetch_pc),
    .branch_predictor_taken_and_btb_valid (taken_o),
    .btb_hit                              (hit_o),
    .btb_target                           (target_o),
    .res                                  (bus),
    .mispredict_count                     (mcount_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int tag;
    int target;
    int ctr;
  } ent_t;

  typedef struct {
    bit v;
    int pc;
    int target;
    bit taken;
    bit uncond;
    bit mis;
    bit bad_tgt;
  } res_t;

  ent_t tbl [N];
  res_t pend;
  int   mcount;
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic int idx_of(int pc);
    return (pc / 2) % N;
  endfunction

  function automatic int tag_of(int pc);
    return pc / (2 * N);
  endfunction

  // Entry contents once resolve p has been folded into entry e.
  function automatic ent_t after_resolve(ent_t e, res_t p);
    ent_t r = e;
    if (e.v && e.tag == tag_of(p.pc)) begin
      if (p.uncond)     r.ctr = 3;
      else if (p.taken) r.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
      else              r.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
      if (p.taken && (p.bad_tgt || e.target != p.target)) r.target = p.target;
    end else if (p.taken) begin
      r = '{v: 1'b1, tag: tag_of(p.pc), target: p.target, ctr: p.uncond ? 3 : 2};
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_model();
    ent_t e;
    bit   h;
    int   i;
    i = idx_of(int'(fetch_pc));
    e = tbl[i];
    if (pend.v && idx_of(pend.pc) == i) e = after_resolve(e, pend);
    h = e.v && (e.tag == tag_of(int'(fetch_pc)));
    check("model_hit", hit_o, h);
    check("model_taken", taken_o, h && e.ctr >= 2);
    check("model_target", target_o, h ? e.target : 0);
    check("model_mcount", mcount_o, mcount);
  endtask

  task automatic model_edge();
    int i;
    if (reset) begin
      for (int k = 0; k < N; k++) tbl[k] = '{v: 1'b0, tag: 0, target: 0, ctr: 1};
      pend.v = 1'b0;
      mcount = 0;
    end else begin
      if (pend.v) begin
        i = idx_of(pend.pc);
        tbl[i] = after_resolve(tbl[i], pend);
        if (pend.mis && mcount < 65535) mcount++;
      end
      pend = '{v: bus.resolve_valid, pc: int'(bus.resolve_pc), target: int'(bus.resolve_target),
               taken: bus.resolve_taken, uncond: bus.resolve_unconditional,
               mis: bus.incorrectly_taken | bus.incorrectly_not_taken | bus.incorrect_target,
               bad_tgt: bus.incorrect_target};
    end
  endtask

  task automatic cycle(bit cmp);
    #1;
    if (cmp) check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(bit v, logic [15:0] pc, logic [15:0] tgt, bit tk, bit unc,
                       bit it, bit int_, bit itg);
    bus.resolve_valid         = v;
    bus.resolve_pc            = pc;
    bus.resolve_target        = tgt;
    bus.resolve_taken         = tk;
    bus.resolve_unconditional = unc;
    bus.incorrectly_taken     = it;
    bus.incorrectly_not_taken = int_;
    bus.incorrect_target      = itg;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic look_check(string tag, logic [15:0] pc, bit h, bit t, logic [15:0] tg);
    fetch_pc = pc;
    #1;
    check({tag, "_hit"}, hit_o, h);
    check({tag, "_taken"}, taken_o, t);
    check({tag, "_target"}, target_o, tg);
  endtask

  logic [15:0] pc_pool  [8] = '{16'h3004, 16'h3044, 16'h3084, 16'h3000,
                                16'h3002, 16'h30c4, 16'h3010, 16'h4010};
  logic [15:0] tgt_pool [4] = '{16'h3020, 16'h4000, 16'h3100, 16'h5000};

  initial begin
    reset    = 1'b1;
    fetch_pc = 16'h0;
    idle();
    pend.v   = 1'b0;
    mcount   = 0;
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;

    // Cold fetch after reset.
    look_check("cold", 16'h3000, 1'b0, 1'b0, 16'h0);
    check("cold_mcount", mcount_o, 0);
    cycle(1'b1);

    // Allocation, forwarded the cycle after capture, then visible from the array.
    drive(1'b1, 16'h3004, 16'h3020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    look_check("pre_alloc", 16'h3004, 1'b0, 1'b0, 16'h0);
    cycle(1'b1);
    idle();
    look_check("fwd_alloc", 16'h3004, 1'b1, 1'b1, 16'h3020);
    cycle(1'b1);
    look_check("alloc", 16'h3004, 1'b1, 1'b1, 16'h3020);
    cycle(1'b1);

    // Hysteresis: WT -> WNT -> SNT, saturate, then one taken only reaches WNT.
    drive(1'b1, 16'h3004, 16'h3020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    look_check("fwd_wnt", 16'h3004, 1'b1, 1'b0, 16'h3020);
    cycle(1'b1);
    idle();
    look_check("snt", 16'h3004, 1'b1, 1'b0, 16'h3020);
    cycle(1'b1);
    drive(1'b1, 16'h3004, 16'h3020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    look_check("snt_sat", 16'h3004, 1'b1, 1'b0, 16'h3020);
    drive(1'b1, 16'h3004, 16'h3020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    look_check("hyst_wnt", 16'h3004, 1'b1, 1'b0, 16'h3020);
    cycle(1'b1);

    // Alias: jsr on the same index with a new tag replaces the entry as ST.
    drive(1'b1, 16'h3044, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    look_check("alias", 16'h3044, 1'b1, 1'b1, 16'h4000);
    check("alias_mcount", mcount_o, 1);
    look_check("victim", 16'h3004, 1'b0, 1'b0, 16'h0);
    cycle(1'b1);
    drive(1'b1, 16'h3044, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    idle();
    cycle(1'b1);
    look_check("st_to_wt", 16'h3044, 1'b1, 1'b1, 16'h4000);
    cycle(1'b1);

    // Reset arrives the edge after a capture: nothing is written.
    drive(1'b1, 16'h3100, 16'h3200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    fetch_pc = 16'h3100;
    cycle(1'b1);
    idle();
    reset = 1'b1;
    cycle(1'b1);
    reset = 1'b0;
    look_check("rst_drop", 16'h3100, 1'b0, 1'b0, 16'h0);
    check("rst_mcount", mcount_o, 0);
    look_check("rst_clear", 16'h3044, 1'b0, 1'b0, 16'h0);
    cycle(1'b1);

    // Random traffic over a small PC pool so aliases and back-to-back hits occur.
    for (int n = 0; n < 800; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      fetch_pc = pc_pool[$urandom_range(0, 7)];
      drive($urandom_range(0, 2) != 0, pc_pool[$urandom_range(0, 7)],
            tgt_pool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      cycle(1'b1);
    end
    reset = 1'b0;
    idle();
    cycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
